// File: rtl/lite16_pkg.sv
// Shared types and sizing for the lite16 register file and operand fetch path.
package lite16_pkg;

   localparam int unsigned DATA_W   = 16;
   localparam int unsigned NUM_REGS = 16;
   localparam int unsigned IDX_W    = 4;
   localparam int unsigned OP_W     = 8;
   localparam int unsigned RF_W     = NUM_REGS * DATA_W;

   // Operand bundle handed to the execute stage
   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [IDX_W-1:0]  rd;
      logic              rd_we;
      logic [OP_W-1:0]   op;
   } operand_bundle_t;

   // Pick register idx out of the flattened register file bus
   function automatic logic [DATA_W-1:0] rf_slice(input logic [RF_W-1:0]  bus,
                                                  input logic [IDX_W-1:0] idx);
      logic [DATA_W-1:0] val;
      val = bus[int'(idx)*DATA_W +: DATA_W];
      return val;
   endfunction

endpackage

// File: rtl/scoreboard.sv
// Pending-write tracker: one bit per register, set by an issuing writer,
// cleared by the matching writeback. A same-cycle set overrides the clear.
module scoreboard
   import lite16_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_REGS-1:0] set_mask,
   input  logic [NUM_REGS-1:0] clr_mask,
   output logic [NUM_REGS-1:0] pending
);

   // Clear completed writes, then mark newly issued writers in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~clr_mask) | set_mask;
      end
   end

endmodule

// File: rtl/operand_fetch_unit.sv
// Operand fetch stage behind register_file: hazard check against the
// pending-write scoreboard, operand select, one-entry output register.
// Optional feature: define OPERAND_FORWARD_EN to bypass wb_data into a
// source whose writeback lands in the same cycle as the fetch.
module operand_fetch_unit
   import lite16_pkg::*;
(
   input  logic                clk,
   input  logic                rst,

   input  logic                req_valid,
   output logic                req_ready,
   input  logic [IDX_W-1:0]    req_rs_a,
   input  logic [IDX_W-1:0]    req_rs_b,
   input  logic [IDX_W-1:0]    req_rd,
   input  logic                req_rd_we,
   input  logic [OP_W-1:0]     req_op,

   input  logic [RF_W-1:0]     rf_data,
   input  logic [NUM_REGS-1:0] wb_en,
   input  logic [DATA_W-1:0]   wb_data,

   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_a,
   output logic [DATA_W-1:0]   out_b,
   output logic [IDX_W-1:0]    out_rd,
   output logic                out_rd_we,
   output logic [OP_W-1:0]     out_op,

   output logic [NUM_REGS-1:0] pending
);

   logic                  hazard_a;
   logic                  hazard_b;
   logic                  hazard_waw;
   logic                  accept;
   logic [DATA_W-1:0]     opnd_a;
   logic [DATA_W-1:0]     opnd_b;
   logic [NUM_REGS-1:0]   set_mask;
   operand_bundle_t       bundle_d;
   operand_bundle_t       bundle_q;
   logic                  out_valid_q;

   // Source operand select and RAW hazard detection
   always_comb begin
      opnd_a   = rf_slice(rf_data, req_rs_a);
      opnd_b   = rf_slice(rf_data, req_rs_b);
`ifdef OPERAND_FORWARD_EN
      hazard_a = pending[req_rs_a];
      hazard_b = pending[req_rs_b];
      // A writeback landing now resolves the hazard and supplies the value
      if (wb_en[req_rs_a]) begin
         opnd_a   = wb_data;
         hazard_a = 1'b0;
      end
      if (wb_en[req_rs_b]) begin
         opnd_b   = wb_data;
         hazard_b = 1'b0;
      end
`else
      // Without a bypass the source must wait until rf_data shows the write
      hazard_a = pending[req_rs_a] | wb_en[req_rs_a];
      hazard_b = pending[req_rs_b] | wb_en[req_rs_b];
`endif
   end

`ifndef OPERAND_FORWARD_EN
   logic unused_wb_data;
   assign unused_wb_data = ^wb_data;
`endif

   // WAW: a second writer may not issue while the first is still in flight,
   // unless the first one retires this very cycle
   assign hazard_waw = req_rd_we & pending[req_rd] & ~wb_en[req_rd];

   // Independent of req_valid so the upstream stage can rely on it
   assign req_ready = (~out_valid_q | out_ready) & ~hazard_a & ~hazard_b & ~hazard_waw;
   assign accept    = req_valid & req_ready;

   // Scoreboard set mask and next bundle contents
   always_comb begin
      set_mask = '0;
      if (accept && req_rd_we) begin
         set_mask[req_rd] = 1'b1;
      end
      bundle_d.a     = opnd_a;
      bundle_d.b     = opnd_b;
      bundle_d.rd    = req_rd;
      bundle_d.rd_we = req_rd_we;
      bundle_d.op    = req_op;
   end

   // One-entry output register; holds steady while execute back-pressures
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         bundle_q    <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         bundle_q    <= bundle_d;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   scoreboard u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_mask (set_mask),
      .clr_mask (wb_en),
      .pending  (pending)
   );

   assign out_valid = out_valid_q;
   assign out_a     = bundle_q.a;
   assign out_b     = bundle_q.b;
   assign out_rd    = bundle_q.rd;
   assign out_rd_we = bundle_q.rd_we;
   assign out_op    = bundle_q.op;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Bench for operand_fetch_unit: directed stimulus pushes expected bundles,
// an independent monitor pops them on every output transfer.
module tb_operand_fetch_unit;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_rs_a;
   logic [3:0]    req_rs_b;
   logic [3:0]    req_rd;
   logic          req_rd_we;
   logic [7:0]    req_op;
   logic [255:0]  rf_data;
   logic [15:0]   wb_en;
   logic [15:0]   wb_data;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   out_a;
   logic [15:0]   out_b;
   logic [3:0]    out_rd;
   logic          out_rd_we;
   logic [7:0]    out_op;
   logic [15:0]   pending;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  rd;
      logic        we;
      logic [7:0]  op;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] rf[16];
   int          n_chk  = 0;
   int          n_fail = 0;

   operand_fetch_unit dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rs_a  (req_rs_a),
      .req_rs_b  (req_rs_b),
      .req_rd    (req_rd),
      .req_rd_we (req_rd_we),
      .req_op    (req_op),
      .rf_data   (rf_data),
      .wb_en     (wb_en),
      .wb_data   (wb_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_rd    (out_rd),
      .out_rd_we (out_rd_we),
      .out_op    (out_op),
      .pending   (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, then check req_ready/pending at the negedge
   task automatic cyc(input logic v, input logic [3:0] ra, input logic [3:0] rb,
                      input logic [3:0] rd, input logic we, input logic [7:0] op,
                      input logic [15:0] wbe, input logic [15:0] wbd, input logic ordy,
                      input logic exp_rdy, input logic [15:0] exp_pend,
                      input logic [15:0] ea, input logic [15:0] eb);
      exp_t e;
      req_valid = v;
      req_rs_a  = ra;
      req_rs_b  = rb;
      req_rd    = rd;
      req_rd_we = we;
      req_op    = op;
      wb_en     = wbe;
      wb_data   = wbd;
      out_ready = ordy;
      for (int i = 0; i < 16; i++) rf_data[i*16 +: 16] = rf[i];
      @(negedge clk);
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("pending", 32'(pending), 32'(exp_pend));
      if (v && exp_rdy) begin
         e.a = ea; e.b = eb; e.rd = rd; e.we = we; e.op = op;
         exp_q.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every transfer to execute must match the oldest expected bundle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_bundle", 32'(out_op), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("out_a", 32'(out_a), 32'(e.a));
               chk("out_b", 32'(out_b), 32'(e.b));
               chk("out_rd", 32'(out_rd), 32'(e.rd));
               chk("out_rd_we", 32'(out_rd_we), 32'(e.we));
               chk("out_op", 32'(out_op), 32'(e.op));
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) rf[i] = {4{4'(i)}};
      rf[3] = 16'h0123;
      rf[7] = 16'h4545;
      rst = 1'b1;
      req_valid = 1'b0; req_rs_a = '0; req_rs_b = '0; req_rd = '0;
      req_rd_we = 1'b0; req_op = '0; wb_en = '0; wb_data = '0; out_ready = 1'b0;
      rf_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_a", 32'(out_a), 32'd0);
      chk("rst_out_b", 32'(out_b), 32'd0);
      chk("rst_out_rd", 32'(out_rd), 32'd0);
      chk("rst_out_rd_we", 32'(out_rd_we), 32'd0);
      chk("rst_out_op", 32'(out_op), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      tick();
      rst = 1'b0;

      // Basic fetch r3/r7
      cyc(1, 4'd3, 4'd7, 4'd1, 0, 8'h11, 16'h0, 16'h0, 1, 1, 16'h0000, 16'h0123, 16'h4545); tick();

      // RAW on r5: writer issues, reader stalls until writeback
      cyc(1, 4'd4, 4'd6, 4'd5, 1, 8'h22, 16'h0, 16'h0, 1, 1, 16'h0000, 16'h4444, 16'h6666); tick();
      cyc(1, 4'd5, 4'd4, 4'd8, 0, 8'h33, 16'h0, 16'h0, 1, 0, 16'h0020, 16'h0, 16'h0); tick();
`ifdef OPERAND_FORWARD_EN
      cyc(1, 4'd5, 4'd4, 4'd8, 0, 8'h33, 16'h0020, 16'hAEAE, 1, 1, 16'h0020, 16'hAEAE, 16'h4444); tick();
      rf[5] = 16'hAEAE;
      cyc(0, 4'd0, 4'd0, 4'd0, 0, 8'h00, 16'h0, 16'h0, 1, 1, 16'h0000, 16'h0, 16'h0); tick();
`else
      cyc(1, 4'd5, 4'd4, 4'd8, 0, 8'h33, 16'h0020, 16'hAEAE, 1, 0, 16'h0020, 16'h0, 16'h0); tick();
      rf[5] = 16'hAEAE;
      cyc(1, 4'd5, 4'd4, 4'd8, 0, 8'h33, 16'h0, 16'h0, 1, 1, 16'h0000, 16'hAEAE, 16'h4444); tick();
`endif

      // Back-pressure: hold bundle 0x44 for three cycles
      cyc(1, 4'd1, 4'd2, 4'd10, 0, 8'h44, 16'h0, 16'h0, 1, 1, 16'h0000, 16'h1111, 16'h2222); tick();
      for (int k = 0; k < 3; k++) begin
         cyc(1, 4'd6, 4'd9, 4'd11, 0, 8'h55, 16'h0, 16'h0, 0, 0, 16'h0000, 16'h0, 16'h0);
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_a", 32'(out_a), 32'h1111);
         chk("hold_b", 32'(out_b), 32'h2222);
         chk("hold_op", 32'(out_op), 32'h44);
         tick();
      end
      // Release: back-to-back accepts, including rs_a == rs_b
      cyc(1, 4'd6, 4'd9, 4'd11, 0, 8'h55, 16'h0, 16'h0, 1, 1, 16'h0000, 16'h6666, 16'h9999); tick();
      cyc(1, 4'd12, 4'd12, 4'd13, 0, 8'h66, 16'h0, 16'h0, 1, 1, 16'h0000, 16'hCCCC, 16'hCCCC); tick();

      // Set wins over a same-cycle clear on r9
      cyc(1, 4'd1, 4'd2, 4'd9, 1, 8'h77, 16'h0200, 16'h1234, 1, 1, 16'h0000, 16'h1111, 16'h2222); tick();
      rf[9] = 16'h1234;

      // WAW on r2
      cyc(1, 4'd1, 4'd4, 4'd2, 1, 8'h88, 16'h0, 16'h0, 1, 1, 16'h0200, 16'h1111, 16'h4444); tick();
      cyc(1, 4'd1, 4'd4, 4'd2, 1, 8'h99, 16'h0, 16'h0, 1, 0, 16'h0204, 16'h0, 16'h0); tick();
      cyc(1, 4'd1, 4'd4, 4'd2, 1, 8'h99, 16'h0, 16'h0, 1, 0, 16'h0204, 16'h0, 16'h0); tick();
      cyc(1, 4'd1, 4'd4, 4'd2, 1, 8'h99, 16'h0004, 16'h2A2A, 1, 1, 16'h0204, 16'h1111, 16'h4444); tick();
      rf[2] = 16'h2A2A;

      // Multi-hot writeback retires r2 and r9 together
      cyc(0, 4'd0, 4'd0, 4'd0, 0, 8'h00, 16'h0204, 16'h5A5A, 1, 1, 16'h0204, 16'h0, 16'h0); tick();
      rf[2] = 16'h5A5A;
      rf[9] = 16'h5A5A;
      cyc(1, 4'd2, 4'd9, 4'd0, 0, 8'hA0, 16'h0, 16'h0, 1, 1, 16'h0000, 16'h5A5A, 16'h5A5A); tick();

      // Reset mid-operation with a held bundle and pending = 0x8008
      cyc(1, 4'd1, 4'd1, 4'd3, 1, 8'hA1, 16'h0, 16'h0, 1, 1, 16'h0000, 16'h1111, 16'h1111); tick();
      cyc(1, 4'd1, 4'd1, 4'd15, 1, 8'hA2, 16'h0, 16'h0, 1, 1, 16'h0008, 16'h1111, 16'h1111); tick();
      rst = 1'b1;
      cyc(0, 4'd0, 4'd0, 4'd0, 0, 8'h00, 16'h0, 16'h0, 0, 0, 16'h8008, 16'h0, 16'h0);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      tick();
      rst = 1'b0;
      void'(exp_q.pop_back());
      cyc(0, 4'd0, 4'd0, 4'd0, 0, 8'h00, 16'h0, 16'h0, 0, 1, 16'h0000, 16'h0, 16'h0);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      chk("post_rst_a", 32'(out_a), 32'd0);
      tick();

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
